// File: rtl/ex_div.sv
// ex_div: iterative 32-bit signed/unsigned restoring divider for the EX stage.
// One quotient bit is produced per cycle. The result appears 33 cycles after
// the start edge (or 1 cycle for a zero divisor) and is held while start stays high.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   signed_div 1 = two's-complement divide, 0 = unsigned (sampled at start)
//   opdata1    dividend (sampled at start)
//   opdata2    divisor  (sampled at start)
//   start      divide request, held high until ready is consumed
//   annul      abort/flush current operation
//   result     {remainder, quotient}, valid while ready=1
//   ready      result valid
//   busy       high while dividing or handling a zero divisor
module ex_div (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        signed_div,
   input  logic [31:0] opdata1,
   input  logic [31:0] opdata2,
   input  logic        start,
   input  logic        annul,
   output logic [63:0] result,
   output logic        ready,
   output logic        busy
);

   typedef enum logic [1:0] {FREE, DIVBYZERO, ON, END} state_t;

   state_t      state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;      // partial remainder
   logic [31:0] dvd_q, dvd_d;      // dividend bits shift out MSB-first, quotient bits shift in at LSB
   logic [31:0] dsr_q, dsr_d;      // divisor magnitude
   logic        sdiv_q, sdiv_d;
   logic        s1_q, s1_d;
   logic        s2_q, s2_d;
   logic [63:0] result_q, result_d;
   logic        ready_q, ready_d;
   logic        busy_q, busy_d;

   logic [32:0] shifted;
   logic [31:0] diff;
   logic        ge;
   logic [31:0] q_fix, r_fix;

   always_comb begin
      // 33-bit partial remainder after shifting in the next dividend bit
      shifted = {rem_q, dvd_q[31]};
      ge      = shifted >= {1'b0, dsr_q};
      // When ge holds the true difference is below 2^32, so a 32-bit subtract is exact
      diff    = shifted[31:0] - dsr_q;
      q_fix   = (sdiv_q && (s1_q != s2_q)) ? (32'd0 - dvd_q) : dvd_q;
      r_fix   = (sdiv_q && s1_q)           ? (32'd0 - rem_q) : rem_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      dvd_d    = dvd_q;
      dsr_d    = dsr_q;
      sdiv_d   = sdiv_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      result_d = result_q;
      ready_d  = ready_q;
      busy_d   = busy_q;

      case (state_q)
         FREE: begin
            ready_d  = 1'b0;
            result_d = '0;
            busy_d   = 1'b0;
            if (start && !annul) begin
               busy_d = 1'b1;
               if (opdata2 == 32'd0) begin
                  state_d = DIVBYZERO;
               end else begin
                  state_d = ON;
                  cnt_d   = '0;
                  rem_d   = '0;
                  dvd_d   = (signed_div && opdata1[31]) ? (32'd0 - opdata1) : opdata1;
                  dsr_d   = (signed_div && opdata2[31]) ? (32'd0 - opdata2) : opdata2;
                  sdiv_d  = signed_div;
                  s1_d    = opdata1[31];
                  s2_d    = opdata2[31];
               end
            end
         end

         DIVBYZERO: begin
            busy_d   = 1'b0;
            result_d = '0;
            if (annul) begin
               state_d = FREE;
               ready_d = 1'b0;
               cnt_d   = '0;
            end else begin
               state_d = END;
               ready_d = 1'b1;
            end
         end

         ON: begin
            if (annul) begin
               state_d  = FREE;
               ready_d  = 1'b0;
               result_d = '0;
               busy_d   = 1'b0;
               cnt_d    = '0;
            end else if (cnt_q == 6'd32) begin
               state_d  = END;
               result_d = {r_fix, q_fix};
               ready_d  = 1'b1;
               busy_d   = 1'b0;
            end else begin
               rem_d = ge ? diff : shifted[31:0];
               dvd_d = {dvd_q[30:0], ge};
               cnt_d = cnt_q + 6'd1;
            end
         end

         END: begin
            if (annul || !start) begin
               state_d  = FREE;
               ready_d  = 1'b0;
               result_d = '0;
               cnt_d    = '0;
            end
         end

         default: state_d = FREE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= FREE;
         cnt_q    <= '0;
         rem_q    <= '0;
         dvd_q    <= '0;
         dsr_q    <= '0;
         sdiv_q   <= 1'b0;
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         result_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         dvd_q    <= dvd_d;
         dsr_q    <= dsr_d;
         sdiv_q   <= sdiv_d;
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         result_q <= result_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign result = result_q;
   assign ready  = ready_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_ex_div.sv
// Testbench for ex_div: table of directed divides plus hand-written
// sequences for annul, annul-in-END and asynchronous reset mid-operation.
module tb_ex_div;

   logic        clk;
   logic        reset_n;
   logic        signed_div;
   logic [31:0] opdata1;
   logic [31:0] opdata2;
   logic        start;
   logic        annul;
   logic [63:0] result;
   logic        ready;
   logic        busy;

   int unsigned checks;
   int unsigned failures;

   ex_div dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .signed_div (signed_div),
      .opdata1    (opdata1),
      .opdata2    (opdata2),
      .start      (start),
      .annul      (annul),
      .result     (result),
      .ready      (ready),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp_q;
      logic [31:0] exp_r;
      int          lat;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Issue one divide, hold start through ready, then release and check clear.
   task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_q, input logic [31:0] exp_r, input int lat);
      int   n;
      bit   got;
      int   busy_cnt;
      @(negedge clk);
      signed_div = sgn;
      opdata1    = a;
      opdata2    = b;
      start      = 1'b1;
      @(posedge clk);                     // E0
      #1;
      check("busy_after_start", {63'd0, busy}, 64'd1);
      busy_cnt = 1;
      @(negedge clk);
      // operands must have been captured at E0
      opdata1    = $urandom;
      opdata2    = $urandom;
      signed_div = ~sgn;
      n   = 0;
      got = 0;
      while (n < 40 && !got) begin
         @(posedge clk);
         #1;
         n++;
         if (ready) got = 1;
         else if (busy) busy_cnt++;
      end
      check("ready_latency", 64'(n), 64'(lat));
      check("ready_seen", {63'd0, got}, 64'd1);
      check("result", result, {exp_r, exp_q});
      check("busy_at_ready", {63'd0, busy}, 64'd0);
      check("busy_cycles", 64'(busy_cnt), 64'(lat));
      @(posedge clk);
      #1;
      check("ready_hold", {63'd0, ready}, 64'd1);
      check("result_hold", result, {exp_r, exp_q});
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      #1;
      check("ready_clear", {63'd0, ready}, 64'd0);
      check("result_clear", result, 64'd0);
   endtask

   initial begin
      int  n;
      bit  seen;
      checks     = 0;
      failures   = 0;
      reset_n    = 1'b0;
      signed_div = 1'b0;
      opdata1    = '0;
      opdata2    = '0;
      start      = 1'b0;
      annul      = 1'b0;

      vecs[0] = '{1'b0, 32'd100,        32'd7,          32'h0000000E, 32'h00000002, 33};
      vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'h00000002,   32'hFFFFFFFD, 32'hFFFFFFFF, 33};
      vecs[2] = '{1'b1, 32'h00000007,   32'hFFFFFFFE,   32'hFFFFFFFD, 32'h00000001, 33};
      vecs[3] = '{1'b0, 32'd5,          32'd0,          32'h00000000, 32'h00000000, 1};
      vecs[4] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000, 32'h00000000, 33};
      vecs[5] = '{1'b0, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF, 32'h00000000, 33};
      vecs[6] = '{1'b0, 32'hFFFFFFF9,   32'h00000002,   32'h7FFFFFFC, 32'h00000001, 33};
      vecs[7] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'h0000000E, 32'hFFFFFFFE, 33};
      vecs[8] = '{1'b1, 32'd3,          32'd10,         32'h00000000, 32'h00000003, 33};
      vecs[9] = '{1'b1, 32'h00000000,   32'hFFFFFFFB,   32'h00000000, 32'h00000000, 33};

      #12;
      check("reset_ready", {63'd0, ready}, 64'd0);
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_result", result, 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 10; i++)
         run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].exp_q, vecs[i].exp_r, vecs[i].lat);

      // Annul during ON: operation discarded, ready never rises
      @(negedge clk);
      signed_div = 1'b0;
      opdata1    = 32'hFFFFFFFF;
      opdata2    = 32'd3;
      start      = 1'b1;
      @(posedge clk);                     // E0
      repeat (9) @(posedge clk);          // E9
      @(negedge clk);
      annul = 1'b1;
      start = 1'b0;
      @(posedge clk);                     // E10
      #1;
      check("annul_busy", {63'd0, busy}, 64'd0);
      check("annul_ready", {63'd0, ready}, 64'd0);
      check("annul_result", result, 64'd0);
      @(negedge clk);
      annul = 1'b0;
      seen  = 0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ready || busy) seen = 1;
      end
      check("annul_no_ready", {63'd0, seen}, 64'd0);
      run_div(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

      // Annul while holding a result in END clears it even with start high
      @(negedge clk);
      signed_div = 1'b0;
      opdata1    = 32'd5;
      opdata2    = 32'd0;
      start      = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("end_ready", {63'd0, ready}, 64'd1);
      @(negedge clk);
      annul = 1'b1;
      @(posedge clk);
      #1;
      check("end_annul_ready", {63'd0, ready}, 64'd0);
      @(negedge clk);
      annul = 1'b0;
      start = 1'b0;
      @(posedge clk);

      // Asynchronous reset in the middle of a divide
      @(negedge clk);
      signed_div = 1'b0;
      opdata1    = 32'd100;
      opdata2    = 32'd7;
      start      = 1'b1;
      @(posedge clk);                     // E0
      repeat (20) @(posedge clk);         // E20
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_ready", {63'd0, ready}, 64'd0);
      check("rst_result", result, 64'd0);
      start = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      run_div(1'b0, 32'd100, 32'd7, 32'h0000000E, 32'h00000002, 33);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
